// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid channel plus the
// valid/ready channel toward decode. The sequencer is the master.
interface pc_fetch_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter plus fetch controller: one outstanding imem request, returned
// instruction held for decode, redirects applied with kill of in-flight fetches.
module pc_fetch_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INCR         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_target,
  output logic                  misalign_err,
  pc_fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {StBoot, StReq, StWait, StHold} state_e;

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic            r_instr_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_misalign;

  logic            w_gnt;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_inc;

  // A grant only counts while the request is actually driven.
  assign w_gnt         = (r_state == StReq) && !stall_i && bus.imem_gnt;
  assign w_redirect_pc = {redirect_target[XLEN-1:2], 2'b00};
  assign w_pc_inc      = r_pc + XLEN'(INCR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StBoot;
      r_pc          <= RESET_VECTOR;
      r_kill        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (redirect_valid) begin
        r_pc <= w_redirect_pc;
      end
      case (r_state)
        StBoot: r_state <= StReq;
        StReq: begin
          if (w_gnt) begin
            r_state <= StWait;
            r_kill  <= redirect_valid;
          end
        end
        StWait: begin
          if (bus.imem_rvalid) begin
            r_kill <= 1'b0;
            if (redirect_valid || r_kill) begin
              r_state <= StReq;
            end else begin
              r_instr       <= bus.imem_rdata;
              r_instr_pc    <= r_pc;
              r_pc          <= w_pc_inc;
              r_instr_valid <= 1'b1;
              r_state       <= StHold;
            end
          end else if (redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        StHold: begin
          if (redirect_valid || bus.instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= StReq;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  assign bus.imem_req    = (r_state == StReq) && !stall_i;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign misalign_err    = r_misalign;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misalign_err;

  pc_fetch_sequencer_if #(.XLEN(32)) bus ();

  pc_fetch_sequencer #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .INCR         (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .misalign_err    (misalign_err),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: fetch lifecycle tracked as booting / outstanding / discard / holding.
  bit          m_boot, m_out, m_disc, m_have, m_mis;
  logic [31:0] m_pc, m_instr, m_ipc;

  // Memory responder used by the random phase.
  bit mem_busy;
  int mem_delay;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_out = 1'b0; m_disc = 1'b0; m_have = 1'b0; m_mis = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
  endtask

  task automatic model_edge();
    bit          req_now, granted, resp;
    logic [31:0] tgt;
    if (rst) begin
      model_reset();
      return;
    end
    req_now = !m_boot && !m_out && !m_have && !stall_i;
    granted = req_now && bus.imem_gnt;
    resp    = m_out && bus.imem_rvalid;
    tgt     = {redirect_target[31:2], 2'b00};
    m_mis   = redirect_valid && (redirect_target[1:0] != 2'b00);
    if (m_boot) begin
      m_boot = 1'b0;
      if (redirect_valid) m_pc = tgt;
    end else if (redirect_valid) begin
      m_pc = tgt;
      if (granted) begin
        m_out = 1'b1; m_disc = 1'b1;
      end else if (m_out) begin
        if (resp) begin m_out = 1'b0; m_disc = 1'b0; end
        else m_disc = 1'b1;
      end else if (m_have) begin
        m_have = 1'b0;
      end
    end else if (granted) begin
      m_out = 1'b1;
    end else if (resp) begin
      m_out = 1'b0;
      if (m_disc) m_disc = 1'b0;
      else begin
        m_have = 1'b1; m_instr = bus.imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
      end
    end else if (m_have && bus.instr_ready) begin
      m_have = 1'b0;
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = !m_boot && !m_out && !m_have && !stall_i;
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    check("imem_addr", bus.imem_addr, m_pc);
    check("instr_valid", 32'(bus.instr_valid), 32'(m_have));
    check("instr", bus.instr, m_instr);
    check("instr_pc", bus.instr_pc, m_ipc);
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Directed fetch from REQ at address a; decode stalls hold_cycles before accepting.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int hold_cycles);
    check("fetch_req", 32'(bus.imem_req), 1);
    check("fetch_addr", bus.imem_addr, a);
    bus.instr_ready = 1'b0;
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = d;
    step();
    bus.imem_rvalid = 1'b0;
    check("hold_valid", 32'(bus.instr_valid), 1);
    check("hold_instr", bus.instr, d);
    check("hold_pc", bus.instr_pc, a);
    for (int i = 0; i < hold_cycles; i++) begin
      step();
      check("bp_valid", 32'(bus.instr_valid), 1);
      check("bp_instr", bus.instr, d);
      check("bp_pc", bus.instr_pc, a);
      check("bp_req", 32'(bus.imem_req), 0);
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    check("next_addr", bus.imem_addr, a + 32'd4);
    check("next_valid", 32'(bus.instr_valid), 0);
  endtask

  task automatic rand_drive();
    rst            = ($urandom_range(0, 399) == 0);
    stall_i        = ($urandom_range(0, 3) == 0);
    redirect_valid = ($urandom_range(0, 9) == 0);
    redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
    bus.instr_ready = ($urandom_range(0, 2) != 0);
    bus.imem_rvalid = 1'b0;
    if (mem_busy) begin
      if (mem_delay == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = $urandom;
        mem_busy        = 1'b0;
      end else begin
        mem_delay--;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = $urandom;
    end
    #1;
    bus.imem_gnt = bus.imem_req && !mem_busy && !rst && ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    mem_busy = 1'b0; mem_delay = 0;
    model_reset();
    step();
    step();
    check("rst_req", 32'(bus.imem_req), 0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_instr", bus.instr, 32'h0);

    rst = 1'b0;
    step();
    do_fetch(32'h0000_0000, 32'h1111_0000, 0);
    do_fetch(32'h0000_0004, 32'h2222_0004, 5);

    // Redirect coincident with the grant for 0x8: its data must be dropped.
    check("kill_addr0", bus.imem_addr, 32'h8);
    bus.imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
    step();
    bus.imem_gnt = 1'b0; redirect_valid = 1'b0;
    check("kill_wait_addr", bus.imem_addr, 32'h100);
    check("kill_wait_req", 32'(bus.imem_req), 0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    check("kill_valid", 32'(bus.instr_valid), 0);
    check("kill_instr", bus.instr, 32'h2222_0004);
    check("kill_req", 32'(bus.imem_req), 1);
    check("kill_addr", bus.imem_addr, 32'h100);
    do_fetch(32'h0000_0100, 32'h3333_0100, 0);

    // Misaligned redirect while holding, with decode ready in the same cycle.
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h4444_0104;
    step();
    bus.imem_rvalid = 1'b0;
    check("hr_valid", 32'(bus.instr_valid), 1);
    check("hr_pc", bus.instr_pc, 32'h104);
    bus.instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h202;
    step();
    bus.instr_ready = 1'b0; redirect_valid = 1'b0;
    check("hr_valid_drop", 32'(bus.instr_valid), 0);
    check("hr_mis_hi", 32'(misalign_err), 1);
    check("hr_addr", bus.imem_addr, 32'h200);
    step();
    check("hr_mis_lo", 32'(misalign_err), 0);
    do_fetch(32'h0000_0200, 32'h5555_0200, 0);

    // PC wraps past the top of the address space.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_mis", 32'(misalign_err), 0);
    do_fetch(32'hFFFF_FFFC, 32'h6666_FFFC, 0);
    check("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Stall with a stray grant, then reset while waiting on memory.
    stall_i = 1'b1; bus.imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req", 32'(bus.imem_req), 0);
    end
    stall_i = 1'b0;
    step();
    bus.imem_gnt = 1'b0;
    check("stall_wait_req", 32'(bus.imem_req), 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_instr", bus.instr, 32'h0);
    check("arst_pc", bus.instr_pc, 32'h0);
    check("arst_addr", bus.imem_addr, 32'h0);
    compare();
    step();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h7777_7777;
    step();
    step();
    bus.imem_rvalid = 1'b0;
    step();
    check("late_rvalid", 32'(bus.instr_valid), 0);

    for (int n = 0; n < 4000; n++) begin
      rand_drive();
      step();
      if (bus.imem_gnt) begin
        mem_busy  = 1'b1;
        mem_delay = $urandom_range(0, 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
